// File: rtl/trena_pkg.sv
// Shared definitions for the trena serial sequencer: state codes (which double as
// the db_estado debug codes) and the ASCII constants used to build each frame.
package trena_pkg;

    localparam int N_CHARS_DEF = 4;
    localparam int TIMEOUT_DEF = 50000;

    localparam logic [7:0] ASCII_BASE = 8'h30;
    localparam logic [7:0] TERMINATOR = 8'h23;
    localparam logic [7:0] BAD_DIGIT  = 8'h3F;

    typedef enum logic [3:0] {
        ST_IDLE = 4'h0,
        ST_PREP = 4'h1,
        ST_SEND = 4'h2,
        ST_WAIT = 4'h3,
        ST_NEXT = 4'h4,
        ST_FIM  = 4'h5,
        ST_ERRO = 4'hE
    } estado_t;

endpackage

// File: rtl/trena_bcd2ascii.sv
// Converts one BCD nibble to its ASCII digit; nibbles above 9 become BAD_DIGIT so a
// corrupted measurement is visible on the far end instead of printing garbage.
module trena_bcd2ascii
    import trena_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] caractere
);

    always_comb begin
        if (nibble > 4'd9) begin
            caractere = BAD_DIGIT;
        end else begin
            caractere = ASCII_BASE + {4'b0000, nibble};
        end
    end

endmodule

// File: rtl/trena_serial_seq.sv
// Frame sequencer for the trena UART link: latches a 3-digit BCD distance on start
// and walks the UART TX through hundreds, tens, units and the terminator.
module trena_serial_seq
    import trena_pkg::*;
#(
    parameter int N_CHARS = N_CHARS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [11:0] digitos,
    input  logic        tx_pronto,
    output logic        tx_partida,
    output logic [7:0]  tx_dados,
    output logic        ocupado,
    output logic        fim,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int IDX_W = $clog2(N_CHARS);
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CHARS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]  WD_MAX   = {WD_W{1'b1}};

    estado_t          estado;
    estado_t          proximo;
    logic [IDX_W-1:0] idx;
    logic [11:0]      digitos_q;
    logic [WD_W-1:0]  watchdog;
    logic [3:0]       nibble;
    logic [7:0]       digito_char;
    logic [7:0]       char_atual;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= ST_IDLE;
        end else begin
            estado <= proximo;
        end
    end

    // NOTE: every signal driven in an always_comb gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        proximo = estado;
        case (estado)
            ST_IDLE: if (iniciar) proximo = ST_PREP;
            ST_PREP: proximo = ST_SEND;
            ST_SEND: proximo = ST_WAIT;
            ST_WAIT: begin
                if (tx_pronto) begin
                    proximo = (idx == IDX_LAST) ? ST_FIM : ST_NEXT;
                end else if (watchdog == WD_LAST) begin
                    proximo = ST_ERRO;
                end
            end
            ST_NEXT: proximo = ST_SEND;
            ST_FIM:  proximo = ST_IDLE;
            ST_ERRO: proximo = ST_IDLE;
            default: proximo = ST_IDLE;
        endcase
    end

    // Datapath: frame latch, char index and the WAIT watchdog, all steered by state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx       <= '0;
            digitos_q <= '0;
            watchdog  <= '0;
        end else begin
            case (estado)
                ST_PREP: begin
                    digitos_q <= digitos;
                    idx       <= '0;
                    watchdog  <= '0;
                end
                ST_WAIT: begin
                    if (watchdog != WD_MAX) begin
                        watchdog <= watchdog + WD_W'(1);
                    end
                end
                ST_NEXT: begin
                    if (idx != IDX_LAST) begin
                        idx <= idx + IDX_W'(1);
                    end
                    watchdog <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nibble = digitos_q[3:0];
        case (idx)
            IDX_W'(0): nibble = digitos_q[11:8];
            IDX_W'(1): nibble = digitos_q[7:4];
            default:   nibble = digitos_q[3:0];
        endcase
    end

    trena_bcd2ascii u_bcd2ascii (
        .nibble    (nibble),
        .caractere (digito_char)
    );

    assign char_atual = (idx == IDX_LAST) ? TERMINATOR : digito_char;

    // Moore outputs: decoded from the state register and registered datapath only.
    always_comb begin
        tx_partida = 1'b0;
        tx_dados   = 8'h00;
        ocupado    = (estado != ST_IDLE);
        fim        = 1'b0;
        erro       = 1'b0;
        db_estado  = estado;
        case (estado)
            ST_SEND: begin
                tx_partida = 1'b1;
                tx_dados   = char_atual;
            end
            ST_WAIT: tx_dados = char_atual;
            ST_NEXT: tx_dados = char_atual;
            ST_FIM:  fim      = 1'b1;
            ST_ERRO: erro     = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trena_serial_seq.sv
// Scoreboard bench for trena_serial_seq: directed frames push expected chars/events,
// a monitor pops them as the DUT pulses tx_partida, fim or erro.
module tb_trena_serial_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic [11:0] digitos;
    logic        tx_pronto;
    logic        tx_partida;
    logic [7:0]  tx_dados;
    logic        ocupado;
    logic        fim;
    logic        erro;
    logic [3:0]  db_estado;

    logic uart_pronto = 1'b0;
    logic spur;
    logic uart_on;
    assign tx_pronto = uart_pronto | spur;

    int n_tests = 0;
    int n_fail  = 0;
    int part_count = 0;
    logic [7:0] exp_chars[$];
    logic [7:0] exp_evt[$];
    logic [7:0] cur_char = 8'h00;

    trena_serial_seq #(.TIMEOUT(20)) dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .digitos    (digitos),
        .tx_pronto  (tx_pronto),
        .tx_partida (tx_partida),
        .tx_dados   (tx_dados),
        .ocupado    (ocupado),
        .fim        (fim),
        .erro       (erro),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push4(input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] c2, input logic [7:0] c3);
        exp_chars.push_back(c0);
        exp_chars.push_back(c1);
        exp_chars.push_back(c2);
        exp_chars.push_back(c3);
    endtask

    task automatic start_pulse();
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic wait_partida(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (tx_partida) return;
        end
        check("partida_timeout", 32'(tx_partida), 1);
    endtask

    task automatic wait_fim(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (fim) return;
        end
        check("fim_timeout", 32'(fim), 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!ocupado) return;
        end
        check("idle_timeout", 32'(ocupado), 0);
    endtask

    // UART model: answers tx_pronto 10 clocks after each partida while enabled.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clock);
            uart_pronto = 1'b0;
            if (reset) begin
                cnt = 0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) uart_pronto = 1'b1;
                end
                if (tx_partida && uart_on) cnt = 10;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (tx_partida) begin
                    part_count++;
                    check("partida_expected", 32'(exp_chars.size() > 0), 1);
                    if (exp_chars.size() > 0) begin
                        cur_char = exp_chars.pop_front();
                        check("char", 32'(tx_dados), 32'(cur_char));
                    end
                end
                if (db_estado == 4'h3) check("dados_stable", 32'(tx_dados), 32'(cur_char));
                if (fim) begin
                    check("fim_expected", 32'(exp_evt.size() > 0), 1);
                    if (exp_evt.size() > 0) check("event_fim", 32'(8'h46), 32'(exp_evt.pop_front()));
                end
                if (erro) begin
                    check("erro_expected", 32'(exp_evt.size() > 0), 1);
                    if (exp_evt.size() > 0) check("event_erro", 32'(8'h45), 32'(exp_evt.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int n;
        reset   = 1'b0;
        iniciar = 1'b0;
        digitos = 12'h000;
        spur    = 1'b0;
        uart_on = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("rst_partida", 32'(tx_partida), 0);
        check("rst_dados",   32'(tx_dados),   0);
        check("rst_ocupado", 32'(ocupado),    0);
        check("rst_fim",     32'(fim),        0);
        check("rst_erro",    32'(erro),       0);
        check("rst_estado",  32'(db_estado),  0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 1: basic frame, latency of PREP and first partida
        digitos = 12'h123;
        push4(8'h31, 8'h32, 8'h33, 8'h23);
        exp_evt.push_back(8'h46);
        p0 = part_count;
        start_pulse();
        check("t1_lat_prep", 32'(db_estado), 1);
        check("t1_lat_ocupado", 32'(ocupado), 1);
        @(negedge clock);
        check("t1_lat_send", 32'(tx_partida), 1);
        wait_idle(200);
        check("t1_partidas", part_count - p0, 4);
        check("t1_fim_seen", exp_evt.size(), 0);
        check("t1_ocupado_low", 32'(ocupado), 0);

        // 2: bad BCD nibble substituted with '?'
        digitos = 12'h0A7;
        push4(8'h30, 8'h3F, 8'h37, 8'h23);
        exp_evt.push_back(8'h46);
        start_pulse();
        wait_idle(200);
        check("t2_chars_done", exp_chars.size(), 0);
        check("t2_fim_seen", exp_evt.size(), 0);

        // 3: iniciar held, digitos changed mid-frame
        digitos = 12'h456;
        push4(8'h34, 8'h35, 8'h36, 8'h23);
        exp_evt.push_back(8'h46);
        push4(8'h37, 8'h38, 8'h39, 8'h23);
        exp_evt.push_back(8'h46);
        p0 = part_count;
        iniciar = 1'b1;
        repeat (30) @(negedge clock);
        digitos = 12'h789;
        wait_fim(200);
        @(negedge clock);
        check("t3_idle_between", 32'(db_estado), 0);
        @(negedge clock);
        check("t3_restart_prep", 32'(db_estado), 1);
        iniciar = 1'b0;
        wait_idle(200);
        check("t3_partidas", part_count - p0, 8);

        // 4: UART never answers, watchdog abort
        uart_on = 1'b0;
        digitos = 12'h555;
        exp_chars.push_back(8'h35);
        exp_evt.push_back(8'h45);
        start_pulse();
        wait_partida(10);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            n = i;
            if (erro) break;
        end
        check("t4_erro_latency", n, 21);
        check("t4_erro_state", 32'(db_estado), 32'hE);
        @(negedge clock);
        check("t4_idle", 32'(db_estado), 0);
        check("t4_ocupado", 32'(ocupado), 0);
        check("t4_evt_done", exp_evt.size(), 0);
        uart_on = 1'b1;

        // 5: reset during WAIT of the second char
        digitos = 12'h246;
        exp_chars.push_back(8'h32);
        exp_chars.push_back(8'h34);
        start_pulse();
        wait_partida(10);
        wait_partida(30);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("t5_rst_partida", 32'(tx_partida), 0);
        check("t5_rst_dados",   32'(tx_dados),   0);
        check("t5_rst_ocupado", 32'(ocupado),    0);
        check("t5_rst_estado",  32'(db_estado),  0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        p0 = part_count;
        repeat (15) @(negedge clock);
        check("t5_no_partida", part_count - p0, 0);
        push4(8'h32, 8'h34, 8'h36, 8'h23);
        exp_evt.push_back(8'h46);
        start_pulse();
        wait_idle(200);
        check("t5_restart_done", exp_chars.size(), 0);

        // 6: spurious tx_pronto in IDLE and in SEND
        repeat (2) @(negedge clock);
        spur = 1'b1;
        @(negedge clock);
        spur = 1'b0;
        check("t6_idle_stays", 32'(db_estado), 0);
        digitos = 12'h908;
        push4(8'h39, 8'h30, 8'h38, 8'h23);
        exp_evt.push_back(8'h46);
        start_pulse();
        wait_partida(10);
        spur = 1'b1;
        @(negedge clock);
        spur = 1'b0;
        check("t6_in_wait", 32'(db_estado), 3);
        check("t6_char_kept", 32'(tx_dados), 32'h39);
        wait_idle(200);

        repeat (3) @(negedge clock);
        check("end_chars_empty", exp_chars.size(), 0);
        check("end_evt_empty", exp_evt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
